// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin burst arbiter driving a shared 8:1 bit mux
// Optional: define MUX8_ARB_GAP_EN to insert one dead cycle on every grant release.
module mux8_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       last,
  output logic       out
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       gnt_n;
  logic [2:0]       sel_n;
  logic             busy_n, last_n;
  logic             do_pick, release_now;
  logic [2:0]       base;
  logic [3:0]       pick_r;

  // Cyclic search starting at base; bit 3 flags a hit, bits 2:0 hold the index.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] b);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 0; i < 8; i++) begin
      idx = b + 3'(i);
      if (!res[3] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    gnt_n       = gnt;
    sel_n       = sel;
    busy_n      = busy;
    do_pick     = 1'b0;
    base        = ptr;
    release_now = (state == GRANT) && (!req[sel] || (cnt == CNT_W'(BURST_LEN)));

    case (state)
      IDLE: do_pick = 1'b1;
      GRANT: begin
        if (!release_now) begin
          cnt_n = cnt + 1'b1;
        end else begin
          ptr_n = sel + 3'd1;
`ifdef MUX8_ARB_GAP_EN
          state_n = GAP;
          gnt_n   = 8'd0;
          busy_n  = 1'b0;
          cnt_n   = '0;
`else
          // Pick in the same cycle with the advanced pointer: zero-cycle handover.
          base    = sel + 3'd1;
          do_pick = 1'b1;
`endif
        end
      end
`ifdef MUX8_ARB_GAP_EN
      GAP: do_pick = 1'b1;
`endif
      default: state_n = IDLE;
    endcase

    pick_r = pick(req, base);
    if (do_pick) begin
      if (pick_r[3]) begin
        state_n = GRANT;
        gnt_n   = 8'd1 << pick_r[2:0];
        sel_n   = pick_r[2:0];
        busy_n  = 1'b1;
        cnt_n   = CNT_W'(1);
      end else begin
        state_n = IDLE;
        gnt_n   = 8'd0;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    end

    last_n = busy_n && (cnt_n == CNT_W'(BURST_LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      cnt   <= '0;
      gnt   <= 8'd0;
      sel   <= 3'd0;
      busy  <= 1'b0;
      last  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      busy  <= busy_n;
      last  <= last_n;
    end
  end

  assign out = busy & d[sel];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_GAP_EN
  localparam int GAPC = 1;
`else
  localparam int GAPC = 0;
`endif
  localparam int P = 4 + GAPC;

  logic       clk, rst_n;
  logic [7:0] req, d;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy, last, out;
  int         total, bad;
  logic [7:0] pat;

  mux8_rr_arbiter #(.BURST_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
    .gnt(gnt), .sel(sel), .busy(busy), .last(last), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    req   = 8'h00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Dead cycle after a release exists only in the gap build.
  task automatic gap_step;
`ifdef MUX8_ARB_GAP_EN
    check("gap_gnt", gnt, 0);
    check("gap_busy", busy, 0);
    check("gap_out", out, 0);
    tick();
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 8'hFF;
    d     = 8'hFF;
    repeat (2) tick();
    check("rst_gnt", gnt, 0);
    check("rst_sel", sel, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_out", out, 0);

    req   = 8'h00;
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // Single requester: re-granted after each full burst.
    req = 8'h01;
    d   = 8'h01;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("single_gnt", gnt, 8'h01);
      check("single_out", out, 1);
      check("single_last", last, (i == 3) ? 1 : 0);
      tick();
    end
    gap_step();
    check("regrant_gnt", gnt, 8'h01);
    check("regrant_last", last, 0);

    // Asynchronous reset mid-burst.
    rst_n = 1'b0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_busy", busy, 0);
    check("async_out", out, 0);
    check("async_last", last, 0);
    req = 8'h00;
    tick();
    rst_n = 1'b1;
    tick();

    // Full rotation with all requesters active.
    req = 8'hFF;
    d   = 8'hA5;
    pat = 8'hA5;
    tick();
    for (int k = 0; k <= 8 * P; k++) begin
      int s;
      s = (k / P) % 8;
      if ((k % P) < 4) begin
        check("rot_sel", sel, s);
        check("rot_gnt", gnt, 32'(8'd1 << s));
        check("rot_out", out, pat[s]);
        check("rot_busy", busy, 1);
      end else begin
        check("rot_gap_gnt", gnt, 0);
        check("rot_gap_busy", busy, 0);
      end
      tick();
    end

    // Pointer wrap: after requester 2 finishes, ptr=3 so requester 0 wins.
    do_reset();
    req = 8'h04;
    d   = 8'h04;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wrap_sel2", sel, 2);
      check("wrap_last", last, (i == 3) ? 1 : 0);
      if (i == 3) req = 8'h05;
      tick();
    end
    gap_step();
    check("wrap_sel", sel, 0);
    check("wrap_gnt", gnt, 8'h01);

    // Early release when req[5] drops.
    do_reset();
    req = 8'h20;
    d   = 8'h20;
    tick();
    check("early_sel5", sel, 5);
    check("early_out", out, 1);
    check("early_last1", last, 0);
    req = 8'h21;
    tick();
    check("early_sel5b", sel, 5);
    check("early_last2", last, 0);
    req = 8'h01;
    tick();
    gap_step();
    check("early_gnt", gnt, 8'h01);
    check("early_sel0", sel, 0);
    check("early_last3", last, 0);
    tick();
    tick();
    check("early_cnt3", last, 0);
    tick();
    check("early_cnt4", last, 1);

    // Two requesters: handover from 0 to 1.
    do_reset();
    req = 8'h03;
    d   = 8'h02;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("pair_gnt0", gnt, 8'h01);
      check("pair_out0", out, 0);
      tick();
    end
    gap_step();
    check("pair_gnt1", gnt, 8'h02);
    check("pair_out1", out, 1);
    check("pair_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
